// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory port between core and responder.
package data_mem_responder_pkg;

    localparam int data_width_gp = 32;
    localparam int byte_lanes_gp = data_width_gp / 8;

    typedef struct packed {
        logic                       valid;
        logic                       wen;
        logic [byte_lanes_gp-1:0]   byte_en;
        logic [data_width_gp-1:0]   write_data;
        logic [31:0]                addr;
        logic                       yumi;
    } mem_in_s;

    typedef struct packed {
        logic                       valid;
        logic [data_width_gp-1:0]   read_data;
        logic                       yumi;
    } mem_out_s;

endpackage

// File: rtl/data_mem_responder_resp_fifo.sv
// Synchronous FIFO with a registered head word; head holds its last value while empty.
module data_mem_responder_resp_fifo #(
    parameter int depth_p = 4,
    parameter int width_p = 32
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       push,
    input  logic [width_p-1:0]         push_data,
    input  logic                       pop,
    output logic [width_p-1:0]         head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth_p):0]   count
);

    localparam int ptr_w = $clog2(depth_p);

    logic [ptr_w:0]       wptr;
    logic [ptr_w:0]       rptr;
    logic [ptr_w:0]       rptr_nxt;
    logic [width_p-1:0]   store [depth_p];
    logic                 do_push;
    logic                 do_pop;

    assign count    = wptr - rptr;
    assign empty    = (count == '0);
    assign full     = (count == (ptr_w+1)'(depth_p));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign rptr_nxt = rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wptr[ptr_w-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wptr <= '0;
            rptr <= '0;
            head <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr_nxt;
            end
            // Head tracks the oldest entry; a push into an empty (or draining) FIFO bypasses storage.
            if (do_push && (empty || (do_pop && count == (ptr_w+1)'(1)))) begin
                head <= push_data;
            end else if (do_pop && count > (ptr_w+1)'(1)) begin
                head <= store[rptr_nxt[ptr_w-1:0]];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-enable SRAM, fixed-latency read pipeline, in-order response buffer.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2,
    parameter int resp_depth_p = 4
) (
    input  logic                              clk,
    input  logic                              n_reset,
    input  mem_in_s                           mem_req_i,
    output mem_out_s                          mem_resp_o,
    output logic [$clog2(resp_depth_p):0]     outstanding_o,
    output logic                              addr_err_o
);

    localparam int cnt_w = $clog2(resp_depth_p) + 1;

    logic [data_width_gp-1:0]   sram [2**addr_width_p];
    logic [addr_width_p-1:0]    idx;
    logic                       upper_bad;
    logic                       accept;
    logic                       wr_accept;
    logic                       rd_accept;
    logic [cnt_w-1:0]           outstanding;
    logic [latency_p-1:0]       pipe_v;
    logic [data_width_gp-1:0]   pipe_d [latency_p];
    logic                       resp_pop;
    logic [data_width_gp-1:0]   fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [cnt_w-1:0]           fifo_count;
    logic                       unused_ok;

    assign idx       = mem_req_i.addr[addr_width_p+1:2];
    assign upper_bad = |mem_req_i.addr[31:addr_width_p+2];
    assign accept    = n_reset & mem_req_i.valid &
                       (mem_req_i.wen | (outstanding < cnt_w'(resp_depth_p)));
    assign wr_accept = accept & mem_req_i.wen;
    assign rd_accept = accept & ~mem_req_i.wen;
    assign resp_pop  = ~fifo_empty & mem_req_i.yumi;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int k = 0; k < byte_lanes_gp; k++) begin
                if (mem_req_i.byte_en[k]) begin
                    sram[idx][8*k +: 8] <= mem_req_i.write_data[8*k +: 8];
                end
            end
        end
    end

    // Data stages carry no reset; only the valid bits decide what reaches the buffer.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            pipe_d[0] <= sram[idx];
        end
        for (int i = 1; i < latency_p; i++) begin
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pipe_v      <= '0;
            outstanding <= '0;
            addr_err_o  <= 1'b0;
        end else begin
            pipe_v[0] <= rd_accept;
            for (int i = 1; i < latency_p; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            case ({rd_accept, resp_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (accept && upper_bad) begin
                addr_err_o <= 1'b1;
            end
        end
    end

    data_mem_responder_resp_fifo #(
        .depth_p (resp_depth_p),
        .width_p (data_width_gp)
    ) resp_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (pipe_v[latency_p-1]),
        .push_data (pipe_d[latency_p-1]),
        .pop       (resp_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outstanding gating guarantees the buffer never fills past capacity, so full/count go unused.
    assign unused_ok = &{1'b0, fifo_full, fifo_count, mem_req_i.addr[1:0]};

    always_comb begin
        mem_resp_o           = '0;
        mem_resp_o.valid     = ~fifo_empty;
        mem_resp_o.read_data = fifo_head;
        mem_resp_o.yumi      = accept;
    end

    assign outstanding_o = outstanding;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a queue-based timing model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       n_reset;
    mem_in_s    req;
    mem_out_s   resp;
    logic [2:0] outstanding;
    logic       addr_err;

    data_mem_responder #(
        .addr_width_p (AW),
        .latency_p    (LAT),
        .resp_depth_p (DEPTH)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .mem_req_i     (req),
        .mem_resp_o    (resp),
        .outstanding_o (outstanding),
        .addr_err_o    (addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: word memory, queue of pending reads stamped with their visible cycle.
    typedef struct {
        int          ready;
        logic [31:0] data;
    } pend_t;

    logic [31:0] mmem [2**AW];
    pend_t       pq [$];
    int          cyc = 0;
    logic [31:0] last_data = '0;
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] a, input logic cy);
        logic  exp_v;
        logic  exp_y;
        int    widx;
        pend_t p;
        req.valid      = v;
        req.wen        = w;
        req.byte_en    = be;
        req.write_data = wd;
        req.addr       = a;
        req.yumi       = cy;
        #1;
        exp_v = (pq.size() > 0) && (pq[0].ready <= cyc);
        exp_y = v && (w || pq.size() < DEPTH);
        check("valid", 32'(resp.valid), 32'(exp_v));
        check("read_data", resp.read_data, exp_v ? pq[0].data : last_data);
        check("yumi", 32'(resp.yumi), 32'(exp_y));
        check("outstanding", 32'(outstanding), 32'(pq.size()));
        check("addr_err", 32'(addr_err), 32'(m_err));
        @(posedge clk);
        cyc++;
        if (exp_v && cy) begin
            last_data = pq[0].data;
            void'(pq.pop_front());
        end
        if (exp_y) begin
            widx = int'(a[AW+1:2]);
            if (a[31:AW+2] != '0) m_err = 1'b1;
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) mmem[widx][8*k +: 8] = wd[8*k +: 8];
            end else begin
                p.ready = cyc + LAT;
                p.data  = mmem[widx];
                pq.push_back(p);
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic cy);
        step(1'b1, 1'b1, be, d, a, cy);
    endtask

    task automatic rd(input logic [31:0] a, input logic cy);
        step(1'b1, 1'b0, 4'h0, $urandom, a, cy);
    endtask

    task automatic idle(input int n, input logic cy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, cy);
    endtask

    task automatic do_reset();
        n_reset        = 1'b0;
        req.valid      = 1'b1;
        req.wen        = 1'b0;
        req.byte_en    = 4'h0;
        req.write_data = '0;
        req.addr       = 32'h4;
        req.yumi       = 1'b0;
        #1;
        check("rst_yumi", 32'(resp.yumi), 32'h0);
        @(posedge clk);
        cyc++;
        pq.delete();
        m_err     = 1'b0;
        last_data = '0;
        @(negedge clk);
        check("rst_valid", 32'(resp.valid), 32'h0);
        check("rst_data", resp.read_data, 32'h0);
        check("rst_outstanding", 32'(outstanding), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        check("rst_yumi_held", 32'(resp.yumi), 32'h0);
        n_reset   = 1'b1;
        req.valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 2**AW; i++) mmem[i] = '0;
        n_reset = 1'b0;
        req     = '0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 32; i++) wr(32'(i * 4), $urandom, 4'hF, 1'b1);

        wr(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        rd(32'h10, 1'b1);
        idle(4, 1'b1);

        wr(32'h20, 32'h11223344, 4'hF, 1'b1);
        wr(32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
        rd(32'h20, 1'b1);
        idle(4, 1'b1);
        check("partial_write_word", mmem[8], 32'h11BB33DD);

        for (int i = 0; i < 6; i++) rd(32'(i * 4), 1'b0);
        wr(32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);
        rd(32'h40, 1'b1);
        idle(4, 1'b1);

        rd(32'h30, 1'b1);
        wr(32'h30, 32'h5A5A_0F0F, 4'hF, 1'b1);
        rd(32'h30, 1'b1);
        idle(5, 1'b1);

        rd(32'h0000_1008, 1'b1);
        idle(4, 1'b1);
        idle(2, 1'b1);

        rd(32'h4, 1'b0);
        rd(32'h8, 1'b0);
        rd(32'hC, 1'b0);
        do_reset();
        idle(6, 1'b1);
        rd(32'h10, 1'b1);
        rd(32'h20, 1'b1);
        idle(5, 1'b1);

        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 19));
            a  = {(($urandom_range(0, 15) == 0) ? 20'($urandom) : 20'h0),
                  5'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
            if (op == 0) begin
                do_reset();
            end else if (op < 5) begin
                step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ($urandom_range(0, 3) != 0));
            end else if (op < 10) begin
                wr(a, $urandom, 4'($urandom), ($urandom_range(0, 3) != 0));
            end else begin
                rd(a, ($urandom_range(0, 3) != 0));
            end
        end
        idle(10, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
